// File: rtl/dec_mem.sv
// Result memory for decoded polar packets: async-reset register array, registered read.
// Optional macro DEC_MEM_WR_BYPASS_EN selects write-first read-during-write (default read-first).
module dec_mem #(
    parameter int MEM_WIDTH = 140,
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wen,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [MEM_WIDTH-1:0] i_wdata,
    output logic [MEM_WIDTH-1:0] o_rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    logic [MEM_WIDTH-1:0] mem_r [0:MEM_DEPTH-1];
    logic [MEM_DEPTH-1:0] wr_sel;
    logic                 in_range;
    logic [MEM_WIDTH-1:0] rdata_next;

    // Addresses at or beyond MEM_DEPTH match no entry, so such writes fall away.
    generate
        for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = i_wen && (i_addr == ADDR_W'(gi));
        end
    endgenerate

    assign in_range = ({1'b0, i_addr} < DEPTH_L);

    always_comb begin
        rdata_next = '0;
        if (in_range) begin
            rdata_next = mem_r[i_addr];
`ifdef DEC_MEM_WR_BYPASS_EN
            if (i_wen) begin
                rdata_next = i_wdata;
            end
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < MEM_DEPTH; k++) begin
                mem_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MEM_DEPTH; k++) begin
                if (wr_sel[k]) begin
                    mem_r[k] <= i_wdata;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= rdata_next;
        end
    end

endmodule

// File: tb/tb_dec_mem.sv
// Scoreboard bench for dec_mem: a power-of-two instance (64) and a non-power-of-two one (44)
// share stimulus; an array model predicts read data and contents.
module tb_dec_mem;

    localparam int W  = 140;
    localparam int DA = 64;
    localparam int DB = 44;
`ifdef DEC_MEM_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wen = 1'b0;
    logic [5:0]   addr = '0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] rdata_a;
    logic [W-1:0] rdata_b;

    always #5 clk = ~clk;

    dec_mem #(.MEM_WIDTH(W), .MEM_DEPTH(DA)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_wen(wen), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rdata_a)
    );

    dec_mem #(.MEM_WIDTH(W), .MEM_DEPTH(DB)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_wen(wen), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rdata_b)
    );

    typedef struct {
        logic [5:0]   addr;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
    } txn_t;

    txn_t         sb_q[$];
    logic [W-1:0] model_a [DA];
    logic [W-1:0] model_b [DB];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < DA; k++) model_a[k] = '0;
        for (int k = 0; k < DB; k++) model_b[k] = '0;
    endtask

    // One clock of stimulus; expected read data is predicted before the model is updated.
    task automatic cycle(input logic w, input logic [5:0] a, input logic [W-1:0] d);
        txn_t t;
        @(negedge clk);
        wen = w; addr = a; wdata = d;
        t.addr  = a;
        t.exp_a = (BYPASS && w) ? d : model_a[a];
        if (int'(a) < DB) t.exp_b = (BYPASS && w) ? d : model_b[a];
        else              t.exp_b = '0;
        sb_q.push_back(t);
        if (w) begin
            model_a[a] = d;
            if (int'(a) < DB) model_b[a] = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string tag);
        for (int k = 0; k < DA; k++) chk($sformatf("%s mem_a[%0d]", tag, k), dut_a.mem_r[k], model_a[k]);
        for (int k = 0; k < DB; k++) chk($sformatf("%s mem_b[%0d]", tag, k), dut_b.mem_r[k], model_b[k]);
    endtask

    // Reset asserts asynchronously at a falling edge and is held across four rising edges.
    task automatic do_reset(input string tag);
        @(negedge clk);
        wen = 1'b0;
        rst = 1'b1;
        #1;
        model_clear();
        chk({tag, " rdata_a async"}, rdata_a, '0);
        chk({tag, " rdata_b async"}, rdata_b, '0);
        check_mem({tag, " async"});
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: read data is valid one cycle after each issued transaction.
    always @(posedge clk) begin
        txn_t t;
        #1;
        if (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            $display("txn addr=%0d rdata_a=%h rdata_b=%h", t.addr, rdata_a, rdata_b);
            chk($sformatf("rdata_a@%0d", t.addr), rdata_a, t.exp_a);
            chk($sformatf("rdata_b@%0d", t.addr), rdata_b, t.exp_b);
        end
    end

    initial begin
        logic [W-1:0] v;
        model_clear();
        rst = 1'b1;
        #12;
        rst = 1'b0;

        // 1: fill with nonzero data, then reset clears everything immediately
        for (int k = 0; k < DA; k++) begin
            v = rand_word() | W'(1);
            cycle(1'b1, 6'(k), v);
        end
        check_mem("preload");
        do_reset("reset");
        for (int k = 0; k < 4; k++) cycle(1'b0, 6'(k * 13), rand_word());
        check_mem("post_reset");

        // 2: sequential fill of 0..43 with the address in the low byte
        for (int k = 0; k < 44; k++) begin
            v = '0;
            v[7:0] = 8'(k);
            cycle(1'b1, 6'(k), v);
        end
        check_mem("fill");

        // 3: plain read latency
        cycle(1'b0, 6'd7, '0);
        chk("latency addr7", rdata_a, W'(8'h07));

        // 4: read-during-write on the same address
        cycle(1'b1, 6'd3, W'(8'hAA));
        cycle(1'b1, 6'd3, W'(8'h55));
        chk("rdw rdata", rdata_a, BYPASS ? W'(8'h55) : W'(8'hAA));
        chk("rdw mem3", dut_a.mem_r[3], W'(8'h55));

        // 5: back-to-back writes to one address
        cycle(1'b1, 6'd10, W'(1));
        cycle(1'b1, 6'd10, W'(2));
        cycle(1'b1, 6'd10, W'(3));
        check_mem("hold10");

        // 6: out-of-range write on the 44-deep instance
        cycle(1'b1, 6'd50, W'(8'hFF));
        chk("oor rdata_b", rdata_b, '0);
        check_mem("oor");

        // Random traffic with one reset in the middle
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset("mid_reset");
            cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), rand_word());
        end
        cycle(1'b0, 6'd0, '0);
        check_mem("final");

        @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_mem.md
Name: dec_mem

Overview:
- Single-port, write-dominant result memory that stores decoded packet words produced by the polar decoder, one word per packet index.
- Sits between polar_decoder's write port (waddr/wdata) and the verification environment.
- The bench reads the contents hierarchically after proc_done and also through the registered read port.
- Behavioural, synthesizable register-array model. Every entry has reset.

Parameters:
- MEM_WIDTH, 140, bits per word (decoded-bit vector of one packet).
- MEM_DEPTH, 64, number of words. Any value ≥2 is legal; it need not be a power of two.
- ADDR_W, $clog2(MEM_DEPTH), address width. Derived; never overridden.

Ports:
- i_clk  input  1  clock. All state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_wen  input  1  write enable, active high. Tied to 1 at system level, so the memory writes every cycle.
- i_addr  input  ADDR_W  shared read/write address.
- i_wdata  input  MEM_WIDTH  write data.
- o_rdata  output  MEM_WIDTH  registered read data.

Behaviour:
- Storage array must be named mem_r, declared [MEM_WIDTH-1:0] mem_r [0:MEM_DEPTH-1]. Benches access mem_r[k] hierarchically and also preload or inspect it with $readmemb.
- Reset (i_rst=1, asynchronous assert, released synchronously to i_clk by the environment):
  - every mem_r entry = 0
  - o_rdata = 0
  - reset dominates any write in the same cycle
- Write: on a rising edge with i_rst=0, i_wen=1 and i_addr<MEM_DEPTH, set mem_r[i_addr] <= i_wdata. Full-width write; no byte enables.
- i_wen=0: array unchanged.
- Read:
  - o_rdata <= mem_r[i_addr] on every rising edge, regardless of i_wen. One-cycle latency.
  - Default read-during-write to the same address is read-first: o_rdata gets the old content.
- Out of range (i_addr ≥ MEM_DEPTH, possible only for non-power-of-two depth):
  - a write is ignored
  - the read returns 0 next cycle
- Repeated writes to the same address in consecutive cycles: the last write wins, with no hazard.
- Reset asserted mid-operation: all contents are lost immediately and o_rdata is 0 asynchronously. The first write after release takes effect on the first rising edge with i_rst=0.
- No X propagation: with defined inputs after reset, o_rdata is never X.
- No other outputs, no handshake, no state machine.

Optional Feature:
- Macro DEC_MEM_WR_BYPASS_EN.
- When defined, read-during-write to the same in-range address is write-first: o_rdata <= i_wdata in that cycle.
- When undefined, it is read-first (old data).
- The array update is identical in both builds.

Test Plan:
1. Reset and clear: preload mem_r[0..63] with nonzero values, then pulse i_rst=1 for 4 cycles.
   - All entries = 0 and o_rdata = 0 during reset, before any clock edge.
   - Both remain 0 after release with i_wen=0.
2. Sequential fill: i_wen=1, addresses 0..43, wdata = address replicated into the low byte (e.g. addr 5 -> 140'h05).
   - mem_r[k] equals the written value for k<44.
   - mem_r[44..63] = 0.
3. Read latency: after test 2, i_wen=0, drive i_addr=7 at edge n.
   - o_rdata = 140'h07 after edge n+1, not before.
4. Read-during-write: mem_r[3]=140'hAA, write 140'h55 to addr 3.
   - Same-edge o_rdata = 140'hAA without the macro, 140'h55 with DEC_MEM_WR_BYPASS_EN.
   - mem_r[3] = 140'h55 in both builds.
5. Continuous write hold: i_wen tied 1, i_addr held at 10 while wdata changes every cycle: 1, 2, 3.
   - mem_r[10] = 3 at the end.
   - No other entry changes.
6. Non-power-of-two depth: MEM_DEPTH=44 (ADDR_W=6), write 140'hFF to addr 50.
   - No entry changes.
   - o_rdata = 0 the next cycle.
